// File: rtl/pwl_pkg.sv
// Shared constants and width helpers for the piecewise-linear evaluator.
package pwl_pkg;

   localparam logic [1:0] CFG_BP = 2'd0;
   localparam logic [1:0] CFG_K  = 2'd1;
   localparam logic [1:0] CFG_B  = 2'd2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

   // k*x + b needs one guard bit above the full product width
   function automatic int sum_width(input int dw, input int cw);
      return dw + cw + 1;
   endfunction

endpackage

// File: rtl/pwl_seg_search.sv
// Segment index = count of breakpoints that x is greater than or equal to.
module pwl_seg_search
   import pwl_pkg::*;
#(
   parameter int DW   = 14,
   parameter int NSEG = 10,
   parameter int SEGW = clog2(NSEG)
) (
   input  logic signed [DW-1:0]   x,
   input  logic [(NSEG-1)*DW-1:0] bp_flat,
   output logic [SEGW-1:0]        seg
);

   // Plain count, so a non-ascending table still yields a defined index
   always_comb begin
      seg = '0;
      for (int i = 0; i < NSEG - 1; i++) begin
         if (x >= $signed(bp_flat[i*DW +: DW])) seg = seg + SEGW'(1);
      end
   end

endmodule

// File: rtl/pwl_eval.sv
// Pipelined piecewise-linear evaluator: out = (k[s]*x + b[s]) >>> OUT_SHIFT.
// Build option PWL_SAT_EN: clamp out-of-range results and flag out_sat; otherwise wrap.
module pwl_eval
   import pwl_pkg::*;
#(
   parameter int DW        = 14,
   parameter int CW        = 14,
   parameter int NSEG      = 10,
   parameter int OUT_SHIFT = 0,
   parameter int OW        = 28
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic signed [DW-1:0]               x,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic signed [OW-1:0]               out,
   output logic                               out_sat,
   input  logic                               cfg_we,
   input  logic [1:0]                         cfg_sel,
   input  logic [clog2(NSEG)-1:0]             cfg_addr,
   input  logic [((DW > CW) ? DW : CW)-1:0]   cfg_wdata
);

   localparam int AW = clog2(NSEG);
   localparam int WW = (DW > CW) ? DW : CW;
   localparam int PW = DW + CW;
   localparam int SW = sum_width(DW, CW);
   localparam logic [AW:0] NSEG_V = (AW+1)'(NSEG);
   localparam logic [AW:0] NBP_V  = (AW+1)'(NSEG - 1);

   logic                   addr_ok;
   logic                   wr_pend;
   logic [1:0]             wr_sel;
   logic [AW-1:0]          wr_addr;
   logic [WW-1:0]          wr_data;
   logic signed [DW-1:0]   bp_tab [NSEG-1];
   logic signed [CW-1:0]   k_tab  [NSEG];
   logic signed [CW-1:0]   b_tab  [NSEG];
   logic [(NSEG-1)*DW-1:0] bp_flat;

   logic                   advance;
   logic                   v0, v1, v2;
   logic signed [DW-1:0]   x0, x1;
   logic [AW-1:0]          seg;
   logic signed [CW-1:0]   k1, b1, b2;
   logic signed [PW-1:0]   p2;
   logic signed [SW-1:0]   sum, shifted;
   logic signed [OW-1:0]   res;
   logic                   res_sat;

   always_comb begin
      addr_ok = 1'b0;
      case (cfg_sel)
         CFG_BP:       addr_ok = ({1'b0, cfg_addr} < NBP_V);
         CFG_K, CFG_B: addr_ok = ({1'b0, cfg_addr} < NSEG_V);
         default:      addr_ok = 1'b0;
      endcase
   end

   // Writes commit one edge after capture, so a sample accepted alongside
   // a write still reads the old table in S1.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_pend <= 1'b0;
         wr_sel  <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         for (int i = 0; i < NSEG - 1; i++) bp_tab[i] <= '0;
         for (int i = 0; i < NSEG; i++) begin
            k_tab[i] <= '0;
            b_tab[i] <= '0;
         end
      end else begin
         wr_pend <= cfg_we && addr_ok;
         wr_sel  <= cfg_sel;
         wr_addr <= cfg_addr;
         wr_data <= cfg_wdata;
         if (wr_pend) begin
            case (wr_sel)
               CFG_BP:  bp_tab[wr_addr] <= DW'(wr_data);
               CFG_K:   k_tab[wr_addr]  <= CW'(wr_data);
               CFG_B:   b_tab[wr_addr]  <= CW'(wr_data);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      bp_flat = '0;
      for (int i = 0; i < NSEG - 1; i++) bp_flat[i*DW +: DW] = bp_tab[i];
   end

   pwl_seg_search #(
      .DW   (DW),
      .NSEG (NSEG),
      .SEGW (AW)
   ) u_seg (
      .x       (x0),
      .bp_flat (bp_flat),
      .seg     (seg)
   );

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign sum     = SW'(p2) + SW'(b2);
   assign shifted = sum >>> OUT_SHIFT;

   generate
      if (OW >= SW) begin : g_ext
         assign res     = OW'(shifted);
         assign res_sat = 1'b0;
      end else begin : g_reduce
`ifdef PWL_SAT_EN
         localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
         localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};
         logic fits;
         // In range when all bits above the OW sign bit match it
         assign fits    = (&shifted[SW-1:OW-1]) || !(|shifted[SW-1:OW-1]);
         assign res     = fits ? shifted[OW-1:0] : (shifted[SW-1] ? OMIN : OMAX);
         assign res_sat = !fits;
`else
         assign res     = OW'(shifted);
         assign res_sat = 1'b0;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         x0        <= '0;
         x1        <= '0;
         k1        <= '0;
         b1        <= '0;
         b2        <= '0;
         p2        <= '0;
         out_valid <= 1'b0;
         out       <= '0;
         out_sat   <= 1'b0;
      end else if (advance) begin
         v0        <= in_valid;
         x0        <= x;
         v1        <= v0;
         x1        <= x0;
         k1        <= k_tab[seg];
         b1        <= b_tab[seg];
         v2        <= v1;
         p2        <= PW'(k1) * PW'(x1);
         b2        <= b1;
         out_valid <= v2;
         if (v2) begin
            out     <= res;
            out_sat <= res_sat;
         end
      end
   end

endmodule

// File: tb/tb_pwl_eval.sv
// Directed bench for pwl_eval: stream, backpressure, table timing, scaling and reset.
module tb_pwl_eval;
   import pwl_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [13:0] x;
   logic               out_ready;
   logic               cfg_we;
   logic [1:0]         cfg_sel;
   logic [1:0]         cfg_addr;
   logic [13:0]        cfg_wdata;

   logic               in_ready_m, valid_m, sat_m;
   logic signed [27:0] out_m;
   logic               in_ready_8, valid_8, sat_8;
   logic signed [7:0]  out_8;
   logic               in_ready_s, valid_s, sat_s;
   logic signed [27:0] out_s;

   int     n_tests = 0;
   int     n_fail  = 0;
   longint exp_q [$];

   int     stream_x [6] = '{-200, -100, 50, 0, 100, -50};
   longint stream_y [6] = '{-190, -180, 180, 30, 440, -80};

   always #5 clk = ~clk;

   pwl_eval #(.DW(14), .CW(14), .NSEG(4), .OUT_SHIFT(0), .OW(28)) u_main (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .x(x),
      .out_valid(valid_m), .out_ready(out_ready), .out(out_m), .out_sat(sat_m),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata));

   pwl_eval #(.DW(14), .CW(14), .NSEG(4), .OUT_SHIFT(0), .OW(8)) u_ow8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8), .x(x),
      .out_valid(valid_8), .out_ready(out_ready), .out(out_8), .out_sat(sat_8),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata));

   pwl_eval #(.DW(14), .CW(14), .NSEG(4), .OUT_SHIFT(2), .OW(28)) u_sh2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .x(x),
      .out_valid(valid_s), .out_ready(out_ready), .out(out_s), .out_sat(sat_s),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata));

   task automatic check(input string tag, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [1:0] addr, input int data);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_addr  = addr;
      cfg_wdata = 14'(data);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic push(input int v);
      bit acc;
      int n;
      in_valid = 1'b1;
      x        = 14'(v);
      acc      = 1'b0;
      n        = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready_m;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("accept_timeout", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Every transfer of the main instance must match the next expected value
   always @(negedge clk) begin
      if (!rst && valid_m && out_ready) begin
         if (exp_q.size() == 0) check("stale_out", valid_m, 0);
         else check("stream_out", out_m, exp_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      longint held;
      rst       = 1'b1;
      in_valid  = 1'b0;
      x         = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_sel   = '0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid", valid_m, 0);
      check("rst_out", out_m, 0);
      check("rst_sat", sat_m, 0);
      check("rst_in_ready", in_ready_m, 1);

      cfg_write(CFG_BP, 2'd0, -100);
      cfg_write(CFG_BP, 2'd1, 0);
      cfg_write(CFG_BP, 2'd2, 100);
      for (int i = 0; i < 4; i++) begin
         cfg_write(CFG_K, 2'(i), i + 1);
         cfg_write(CFG_B, 2'(i), 10 * (i + 1));
      end
      // must be ignored: bp[0]=5000 would move x=-100 into segment 0
      cfg_write(2'd3, 2'd0, 5000);
      cfg_write(CFG_BP, 2'd3, -5000);

      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(stream_y[i]);
         push(stream_x[i]);
      end
      wait_drain();

      fork
         begin
            for (int i = 0; i < 6; i++) begin
               exp_q.push_back(stream_y[i]);
               push(stream_x[i]);
            end
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            held = 0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               if (c == 0) held = out_m;
               else check("stall_hold", out_m, held);
               check("stall_valid", valid_m, 1);
               check("stall_in_ready", in_ready_m, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // k[2]=5 written in the same cycle as x=50 is accepted
      cfg_we    = 1'b1;
      cfg_sel   = CFG_K;
      cfg_addr  = 2'd2;
      cfg_wdata = 14'd5;
      in_valid  = 1'b1;
      x         = 14'sd50;
      exp_q.push_back(180);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      exp_q.push_back(280);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_drain();

      exp_q.push_back(-190);
      exp_q.push_back(440);
      in_valid = 1'b1;
      x        = -14'sd200;
      @(posedge clk);
      #1;
      x = 14'sd100;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("sh2_valid", valid_s, 1);
      check("sh2_neg", out_s, -48);
      check("ow8_valid", valid_8, 1);
`ifdef PWL_SAT_EN
      check("ow8_neg", out_8, -128);
      check("ow8_neg_sat", sat_8, 1);
`else
      check("ow8_neg", out_8, 66);
      check("ow8_neg_sat", sat_8, 0);
`endif
      @(posedge clk);
      #1;
      check("sh2_pos", out_s, 110);
      check("main_sat", sat_m, 0);
`ifdef PWL_SAT_EN
      check("ow8_pos", out_8, 127);
      check("ow8_pos_sat", sat_8, 1);
`else
      check("ow8_pos", out_8, -72);
      check("ow8_pos_sat", sat_8, 0);
`endif
      wait_drain();

      in_valid = 1'b1;
      x        = -14'sd200;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst2_valid", valid_m, 0);
      check("rst2_out", out_m, 0);
      check("rst2_in_ready", in_ready_m, 1);
      repeat (6) @(posedge clk);
      #1;
      check("rst2_quiet", valid_m, 0);
      exp_q.push_back(0);
      push(7);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
